// File: rtl/timer_alarm.sv
// timer_alarm: prescaled free-running 32-bit timer with compare alarm, periodic reload
// and overrun detection, exposed as an Avalon-MM slave with a level interrupt.
module timer_alarm #(
    parameter int TICK_DIV = 50
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        avs_s0_write,
    input  logic        avs_s0_read,
    input  logic [1:0]  avs_s0_address,
    input  logic [31:0] avs_s0_writedata,
    output logic [31:0] avs_s0_readdata,
    output logic        ins_irq0_irq
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] period_q, period_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        fired_q, fired_d;
    logic        overrun_q, overrun_d;
    logic        tick, wr_count, wr_compare, wr_period, wr_ctrl, match, reload;
    logic [31:0] rd_mux;

    always_comb begin
        tick       = presc_q == 16'(TICK_DIV);
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        wr_count   = avs_s0_write && avs_s0_address == 2'd0;
        wr_compare = avs_s0_write && avs_s0_address == 2'd1;
        wr_period  = avs_s0_write && avs_s0_address == 2'd2;
        wr_ctrl    = avs_s0_write && avs_s0_address == 2'd3;
        // a COUNT write on a tick cycle overrides the increment, so no match is evaluated
        match      = state_q == ARMED && tick && !wr_count && count_q + 32'd1 == compare_q;
        reload     = ctrl_q[1] && period_q != 32'd0;
        count_d    = wr_count ? avs_s0_writedata : tick ? count_q + 32'd1 : count_q;
        compare_d  = wr_compare ? avs_s0_writedata : (match && reload) ? compare_q + period_q : compare_q;
        period_d   = wr_period ? avs_s0_writedata : period_q;
        ctrl_d     = wr_ctrl ? avs_s0_writedata[2:0] : ctrl_q;
        fired_d    = match || (fired_q && !(wr_ctrl && avs_s0_writedata[8]));
        overrun_d  = (match && fired_q) || (overrun_q && !(wr_ctrl && avs_s0_writedata[9]));
        state_d    = state_q;
        if (!ctrl_q[0])
            state_d = IDLE;
        else if (state_q == IDLE)
            state_d = ARMED;
        else if (state_q == ARMED && match && !reload)
            state_d = DONE;
        else if (state_q == DONE && wr_compare)
            state_d = ARMED;
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            period_q  <= '0;
            ctrl_q    <= '0;
            fired_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            period_q  <= period_d;
            ctrl_q    <= ctrl_d;
            fired_q   <= fired_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        rd_mux = avs_s0_address == 2'd0 ? count_q :
                 avs_s0_address == 2'd1 ? compare_q :
                 avs_s0_address == 2'd2 ? period_q :
                 {22'd0, overrun_q, fired_q, 5'd0, ctrl_q};
        avs_s0_readdata = avs_s0_read ? rd_mux : 32'd0;
    end

    assign ins_irq0_irq = fired_q && ctrl_q[2];
endmodule

// File: doc/timer_alarm.md
TIMER_ALARM -- requirements
Module: timer_alarm

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50, prescaler terminal value; one tick every TICK_DIV+1 clocks.
REQ-002 SHALL have port csi_clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rsi_reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port avs_s0_write  input  1  Avalon-MM write strobe, single-cycle, no waitrequest.
REQ-005 SHALL have port avs_s0_read  input  1  Avalon-MM read strobe, zero wait states.
REQ-006 SHALL have port avs_s0_address  input  2  register select: 0 COUNT, 1 COMPARE, 2 PERIOD, 3 CTRL_STAT.
REQ-007 SHALL have port avs_s0_writedata  input  32  write data.
REQ-008 SHALL have port avs_s0_readdata  output  32  read data, combinational from registers.
REQ-009 SHALL have port ins_irq0_irq  output  1  level interrupt, = FIRED flag AND IRQ_EN.

Function
REQ-010 Prescaler SHALL be a 16-bit counter that pulses tick for one cycle when it equals TICK_DIV, then returns to 0; otherwise it increments.
REQ-011 COUNT SHALL be a free-running 32-bit counter incremented on every tick, independent of ENABLE, wrapping 0xFFFFFFFF -> 0.
REQ-012 CTRL_STAT write SHALL set bit0 ENABLE, bit1 PERIODIC, bit2 IRQ_EN (RW); bit8 FIRED and bit9 OVERRUN SHALL be write-1-to-clear; all other bits read 0.
REQ-013 avs_s0_readdata SHALL be 0 when avs_s0_read is low, else the addressed register.
REQ-014 FSM states SHALL be IDLE, ARMED, DONE.
REQ-015 IDLE -> ARMED on the clock after ENABLE becomes 1; any state -> IDLE on the clock after ENABLE becomes 0; FIRED/OVERRUN retained.
REQ-016 A match SHALL occur when state is ARMED, tick is high and COUNT+1 equals COMPARE; FIRED SHALL be set on the same edge that COUNT takes the value COMPARE.
REQ-017 On match with PERIODIC=1 and PERIOD!=0: COMPARE <= COMPARE+PERIOD (mod 2^32), state stays ARMED.
REQ-018 On match with PERIODIC=0 or PERIOD=0: state -> DONE; DONE -> ARMED only when COMPARE is written while ENABLE=1.
REQ-019 On match while FIRED is already 1, OVERRUN SHALL be set.
REQ-020 Write to COUNT in the same cycle as tick: written value SHALL load, increment is lost, no match evaluated.
REQ-021 Write to COMPARE in the same cycle as a match: FIRED set from the old COMPARE, written value SHALL replace the periodic reload.
REQ-022 W1C of FIRED/OVERRUN in the same cycle as a set event: set SHALL win.
REQ-023 ins_irq0_irq SHALL change only on clock edges (registered flags, no glitch from bus inputs).

Reset
REQ-024 On rsi_reset_n low, immediately: prescaler, COUNT, COMPARE, PERIOD, CTRL bits, FIRED, OVERRUN = 0; state = IDLE; ins_irq0_irq = 0.
REQ-025 Reset asserted mid-count or in DONE SHALL abort with no pending match after release; prescaler restarts at 0.

Verification
REQ-026 Reset, hold 200 clocks with TICK_DIV=50 -> COUNT reads 3 (ticks at cycles 51,102,153), irq 0.
REQ-027 Write COUNT=0, COMPARE=3, CTRL=0x5 -> irq rises on the edge COUNT becomes 3, state DONE; write CTRL_STAT=0x105 -> irq 0, COUNT keeps running.
REQ-028 COUNT=0, COMPARE=2, PERIOD=2, CTRL=0x7, never clear -> FIRED at COUNT=2, COMPARE reads 4, OVERRUN set at COUNT=4, COMPARE reads 6.
REQ-029 COUNT=0xFFFFFFFE, COMPARE=1, CTRL=0x1 -> COUNT wraps through 0, FIRED set at COUNT=1, irq stays 0 (IRQ_EN=0).
REQ-030 Write COUNT=0x10 on the exact tick cycle -> COUNT reads 0x10 (not 0x11); W1C FIRED on match cycle -> FIRED remains 1.
REQ-031 Assert rsi_reset_n low in ARMED with prescaler at 30 -> all registers 0, readdata 0, no irq after release until re-armed.
